hazard_fwd_ctrl: RTL and testbench

Pipeline hazard and forwarding controller. It drives the `forwarding_sel` inputs of the ID-stage register-data muxes and the stall/bubble controls of the five-stage core. It tracks the destination-register state of the EXE, MEM and WB stages in a private shadow pipeline. From that state it resolves RAW hazards by forwarding where the data exists and stalling where it does not (load-use). It also counts stall cycles for performance monitoring.

---
 rtl/hazard_fwd_ctrl_pkg.sv | 35 +++
 rtl/hazard_fwd_ctrl_fwd_resolve.sv | 47 ++++
 rtl/hazard_fwd_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types for the hazard/forwarding controller: forwarding select
// encoding, shadow pipeline entry and a producer-match helper.
package CorePack;

    localparam int HZ_REG_W = 5;

    // Select encoding for the ID-stage register-data muxes
    typedef enum logic [1:0] {
        FWD_NO  = 2'd0,
        FWD_EXE = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_enum;

    // Destination-register state tracked for one downstream stage
    typedef struct packed {
        logic                valid;
        logic [HZ_REG_W-1:0] rd;
        logic                we;
        logic                is_load;
    } hz_entry_t;

    localparam hz_entry_t HZ_BUBBLE = '{valid: 1'b0, rd: {HZ_REG_W{1'b0}},
                                        we: 1'b0, is_load: 1'b0};

    // Returns {alu_hit, load_hit}: the entry writes a non-zero rd equal to src,
    // split by whether the value comes from an ALU op or from a load.
    function automatic logic [1:0] hz_match(input hz_entry_t e,
                                            input logic [HZ_REG_W-1:0] src);
        logic hit;
        hit = e.valid && e.we && (e.rd != {HZ_REG_W{1'b0}}) && (e.rd == src);
        return {hit & ~e.is_load, hit & e.is_load};
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_resolve.sv
// Combinational RAW resolution for one ID source operand. The youngest
// producer wins; a load that has not yet reached WB cannot be forwarded
// (the MEM path carries the ALU result), so it raises a hazard instead.
module fwd_resolve
    import CorePack::*;
(
    input  logic [HZ_REG_W-1:0] src_i,
    input  logic                use_i,
    input  hz_entry_t           exe_i,
    input  hz_entry_t           mem_i,
    input  hz_entry_t           wb_i,
    output fwd_sel_enum         sel_o,
    output logic                hazard_o
);

    logic [1:0] exe_m_s;
    logic [1:0] mem_m_s;
    logic [1:0] wb_m_s;

    assign exe_m_s = hz_match(exe_i, src_i);
    assign mem_m_s = hz_match(mem_i, src_i);
    assign wb_m_s  = hz_match(wb_i, src_i);

    // Priority search EXE -> MEM -> WB; x0 never matches inside hz_match
    always_comb begin
        sel_o    = FWD_NO;
        hazard_o = 1'b0;
        if (!use_i) begin
            sel_o    = FWD_NO;
            hazard_o = 1'b0;
        end else if (exe_m_s[1]) begin
            sel_o = FWD_EXE;
        end else if (exe_m_s[0]) begin
            hazard_o = 1'b1;
        end else if (mem_m_s[1]) begin
            sel_o = FWD_MEM;
        end else if (mem_m_s[0]) begin
            hazard_o = 1'b1;
        end else if (|wb_m_s) begin
            sel_o = FWD_WB;
        end else begin
            sel_o    = FWD_NO;
            hazard_o = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard and forwarding controller: shadow EXE/MEM/WB destination
// state, per-source forwarding selects, load-use stall/bubble control and a
// saturating stall-cycle counter.
module hazard_fwd_ctrl
    import CorePack::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_we_reg,
    input  logic             id_is_load,
    input  logic             mem_stall,
    input  logic             flush_exe,
    output fwd_sel_enum      fwd_sel_rs1,
    output fwd_sel_enum      fwd_sel_rs2,
    output logic             stall_if_id,
    output logic             bubble_exe,
    output logic [CNT_W-1:0] stall_cycles
);

    hz_entry_t        exe_q, exe_d;
    hz_entry_t        mem_q, mem_d;
    hz_entry_t        wb_q,  wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    hz_entry_t        id_entry_s;
    logic             hz_rs1_s;
    logic             hz_rs2_s;
    logic             load_use_s;

    assign id_entry_s = '{valid: id_valid, rd: id_rd, we: id_we_reg,
                          is_load: id_is_load};

    fwd_resolve u_rs1 (
        .src_i    (id_rs1),
        .use_i    (id_valid & id_use_rs1),
        .exe_i    (exe_q),
        .mem_i    (mem_q),
        .wb_i     (wb_q),
        .sel_o    (fwd_sel_rs1),
        .hazard_o (hz_rs1_s)
    );

    fwd_resolve u_rs2 (
        .src_i    (id_rs2),
        .use_i    (id_valid & id_use_rs2),
        .exe_i    (exe_q),
        .mem_i    (mem_q),
        .wb_i     (wb_q),
        .sel_o    (fwd_sel_rs2),
        .hazard_o (hz_rs2_s)
    );

    assign load_use_s  = hz_rs1_s | hz_rs2_s;
    // A flush kills the ID instruction, so it overrides a load-use stall;
    // a memory stall freezes everything, so no bubble is inserted.
    assign stall_if_id = (load_use_s | mem_stall) & ~flush_exe;
    assign bubble_exe  = (load_use_s | flush_exe) & ~mem_stall;
    assign stall_cycles = cnt_q;

    // Shadow pipeline advance: freeze, advance with bubble, or take ID
    always_comb begin
        exe_d = exe_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (mem_stall) begin
            exe_d = exe_q;
            mem_d = mem_q;
            wb_d  = wb_q;
        end else if (flush_exe || load_use_s) begin
            exe_d = HZ_BUBBLE;
            mem_d = exe_q;
            wb_d  = mem_q;
        end else begin
            exe_d = id_entry_s;
            mem_d = exe_q;
            wb_d  = mem_q;
        end
    end

    // Saturating count of cycles actually lost to load-use stalls
    always_comb begin
        cnt_d = cnt_q;
        if (load_use_s && !mem_stall && !flush_exe && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            exe_q <= HZ_BUBBLE;
            mem_q <= HZ_BUBBLE;
            wb_q  <= HZ_BUBBLE;
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            exe_q <= exe_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: expected outputs are queued when a
// step is driven and popped/compared at the following falling edge.
module tb_hazard_fwd_ctrl;
    import CorePack::*;

    logic        clk;
    logic        rstn;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_we_reg, id_is_load;
    logic        mem_stall, flush_exe;
    fwd_sel_enum fwd_sel_rs1, fwd_sel_rs2;
    logic        stall_if_id, bubble_exe;
    logic [31:0] stall_cycles;

    typedef struct packed {
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic        st;
        logic        bb;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_vec;
    int          n_err;
    logic [31:0] exp_cnt;

    hazard_fwd_ctrl #(.REG_W(5), .CNT_W(32)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_we_reg    (id_we_reg),
        .id_is_load   (id_is_load),
        .mem_stall    (mem_stall),
        .flush_exe    (flush_exe),
        .fwd_sel_rs1  (fwd_sel_rs1),
        .fwd_sel_rs2  (fwd_sel_rs2),
        .stall_if_id  (stall_if_id),
        .bubble_exe   (bubble_exe),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input fwd_sel_enum e1, input fwd_sel_enum e2,
                            input logic es, input logic eb);
        exp_t e;
        e.s1 = e1; e.s2 = e2; e.st = es; e.bb = eb; e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
        end else begin
            e = sb.pop_front();
            cmp({tag, ".sel1"},  {30'd0, fwd_sel_rs1}, {30'd0, e.s1});
            cmp({tag, ".sel2"},  {30'd0, fwd_sel_rs2}, {30'd0, e.s2});
            cmp({tag, ".stall"}, {31'd0, stall_if_id}, {31'd0, e.st});
            cmp({tag, ".bub"},   {31'd0, bubble_exe},  {31'd0, e.bb});
            cmp({tag, ".cnt"},   stall_cycles,         e.cnt);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic we, input logic ld, input logic ms, input logic fl);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_we_reg = we; id_is_load = ld; mem_stall = ms; flush_exe = fl;
    endtask

    // One pipeline cycle: drive, queue expectation, check mid-cycle, clock
    task automatic step(input string tag,
                        input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic we, input logic ld, input logic ms, input logic fl,
                        input fwd_sel_enum e1, input fwd_sel_enum e2,
                        input logic es, input logic eb);
        drive(v, r1, r2, u1, u2, rd, we, ld, ms, fl);
        push_exp(e1, e2, es, eb);
        @(negedge clk);
        check_out(tag);
        @(posedge clk);
        if (es && eb) exp_cnt++;
        #1;
    endtask

    initial begin
        n_vec = 0; n_err = 0; exp_cnt = 32'd0;
        rstn = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        step("reset", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
             FWD_NO, FWD_NO, 1'b0, 1'b0);
        rstn = 1'b1;

        // ALU chain: add x5, then readers at EXE/MEM/WB distance
        step("alu_prod", 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0,
             FWD_NO, FWD_NO, 1'b0, 1'b0);
        step("fwd_exe",  1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0,
             FWD_EXE, FWD_NO, 1'b0, 1'b0);
        step("fwd_mem",  1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0,
             FWD_MEM, FWD_NO, 1'b0, 1'b0);
        step("fwd_wb",   1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0,
             FWD_WB, FWD_MEM, 1'b0, 1'b0);

        // Load-use: lw x7 then add x8,x7,x7 -> two stalls then WB forward
        step("lw_issue", 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0,
             FWD_NO, FWD_NO, 1'b0, 1'b0);
        step("lu_exe",   1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0,
             FWD_NO, FWD_NO, 1'b1, 1'b1);
        step("lu_mem",   1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0,
             FWD_NO, FWD_NO, 1'b1, 1'b1);
        step("lu_wb",    1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0,
             FWD_WB, FWD_WB, 1'b0, 1'b0);

        // x0 destination and x0 sources never forward
        step("x0_prod",  1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0,
             FWD_NO, FWD_NO, 1'b0, 1'b0);
        step("x0_read",  1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0,
             FWD_NO, FWD_NO, 1'b0, 1'b0);

        // Flush during load-use: bubble only, no stall, counter unchanged
        step("flush_lu", 1'b1, 5'd7, 5'd8, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1,
             FWD_NO, FWD_WB, 1'b0, 1'b1);

        // mem_stall freeze with add x5 in EXE and lw x7 in WB
        step("ms_prod",  1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0,
             FWD_NO, FWD_NO, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("ms_hold%0d", i), 1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd9, 1'b1,
                 1'b0, 1'b1, 1'b0, FWD_EXE, FWD_WB, 1'b1, 1'b0);
        end
        step("ms_release", 1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0,
             FWD_EXE, FWD_WB, 1'b0, 1'b0);

        // Same rd in EXE and MEM: youngest (EXE) wins
        step("x9_second", 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0,
             FWD_MEM, FWD_NO, 1'b0, 1'b0);
        step("prio_exe",  1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0,
             FWD_EXE, FWD_EXE, 1'b0, 1'b0);
        step("lu13_exe",  1'b1, 5'd13, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0,
             FWD_NO, FWD_NO, 1'b1, 1'b1);

        // Second stall cycle, then asynchronous reset in the middle of it
        drive(1'b1, 5'd13, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0);
        push_exp(FWD_NO, FWD_NO, 1'b1, 1'b1);
        @(negedge clk);
        check_out("lu13_mem");
        #2;
        rstn = 1'b0;
        exp_cnt = 32'd0;
        #1;
        push_exp(FWD_NO, FWD_NO, 1'b0, 1'b0);
        check_out("rst_mid");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step("post_rst", 1'b1, 5'd13, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0,
             FWD_NO, FWD_NO, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
